// File: rtl/mem_reader_pkg.sv
// -----------------------------------------------------------------------------
// mem_reader_pkg
// Shared definitions for the memory read sequencer:
//   - default address / data widths
//   - FSM state encoding (IDLE=0, READ=1, DRAIN=2, DONE=3)
//   - credit helper used to decide whether another RAM read may be issued
// Optional feature macro used elsewhere in this slice: MEM_READER_CHECKSUM_EN
// -----------------------------------------------------------------------------
package mem_reader_pkg;

    localparam int MR_AW_DEF = 4;
    localparam int MR_DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mr_state_t;

    // A read may be issued only while stored words plus the read already in
    // flight stay below the two buffer slots; this guarantees every returning
    // word has a slot no matter what the consumer does.
    function automatic logic credit_ok(input logic [1:0] count, input logic pending);
        return ({1'b0, count} + {2'b00, pending}) < 3'd2;
    endfunction

endpackage

// File: rtl/mem_reader_if.sv
// -----------------------------------------------------------------------------
// mem_reader_if
// Bundles the RAM read port and the output stream of the read sequencer.
//   ram_re    : read strobe to the RAM
//   ram_addr  : read address, valid with ram_re
//   ram_rdata : RAM data, valid the cycle after ram_re
//   q_valid   : q_data holds a word
//   q_ready   : consumer accepts the word
//   q_data    : output word
// Handshake: a word transfers in every cycle where q_valid and q_ready are both
// high; once q_valid is raised, q_valid and q_data hold until that transfer.
// Modports: master = the reader, slave = RAM + consumer side.
// -----------------------------------------------------------------------------
interface mem_reader_if
    import mem_reader_pkg::*;
#(
    parameter int AW = MR_AW_DEF,
    parameter int DW = MR_DW_DEF
) ();

    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic          q_valid;
    logic          q_ready;
    logic [DW-1:0] q_data;

    modport master (
        output ram_re,
        output ram_addr,
        input  ram_rdata,
        output q_valid,
        input  q_ready,
        output q_data
    );

    modport slave (
        input  ram_re,
        input  ram_addr,
        output ram_rdata,
        input  q_valid,
        output q_ready,
        input  q_data
    );

endinterface

// File: rtl/mem_reader_buf.sv
// -----------------------------------------------------------------------------
// mem_reader_buf
// Two-entry output FIFO with fall-through: a word pushed into an empty buffer
// is presented on q_data/q_valid in the same cycle, and if popped in that
// cycle it is never stored.
// Ports:
//   clk, rstbar : clock, asynchronous active-low reset
//   push        : push_data is written this cycle
//   push_data   : word to write
//   pop         : head word is consumed this cycle (only meaningful with q_valid)
//   q_valid     : a word is presented at q_data
//   q_data      : head word (0 when nothing is presented)
//   count       : number of stored words (0..2), excluding a fall-through word
// -----------------------------------------------------------------------------
module mem_reader_buf
    import mem_reader_pkg::*;
#(
    parameter int DW = MR_DW_DEF
) (
    input  logic          clk,
    input  logic          rstbar,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          q_valid,
    output logic [DW-1:0] q_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;

    logic empty;
    logic bypass;
    logic do_write;
    logic do_read;

    always_comb begin
        empty    = (count_q == 2'd0);
        // Word arrives into an empty buffer and leaves in the same cycle.
        bypass   = empty && push && pop;
        do_write = push && !bypass;
        do_read  = pop && !empty;

        q_valid  = !empty || push;
        if (!empty) begin
            q_data = mem_q[rd_ptr_q];
        end else if (push) begin
            q_data = push_data;
        end else begin
            q_data = '0;
        end

        // On a full buffer with push and pop, wr_ptr equals rd_ptr: the new
        // word overwrites the slot being vacated and becomes the tail.
        rd_ptr_d = do_read  ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = do_write ? ~wr_ptr_q : wr_ptr_q;
        count_d  = count_q + {1'b0, do_write} - {1'b0, do_read};
    end

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_reader.sv
// -----------------------------------------------------------------------------
// mem_reader
// Read-side sequencer for the word RAM. On an accepted start it streams len
// consecutive words beginning at base (address wraps modulo 2^AW) out of a
// synchronous RAM with one cycle of read latency, through a 2-entry output
// buffer so consumer backpressure never drops or reorders data.
// Ports:
//   clk, rstbar  : clock, asynchronous active-low reset
//   start        : begin a transfer (sampled only in IDLE)
//   base, len    : first address and word count (0..2^AW), sampled with start
//   busy         : high in READ, DRAIN and DONE
//   done         : one-cycle pulse when the transfer completes
//   sum          : running XOR of words handed out this transfer
//                  (present only with MEM_READER_CHECKSUM_EN defined)
//   dbg_state_o  : current FSM state
//   bus          : RAM read port and output stream (mem_reader_if.master)
// -----------------------------------------------------------------------------
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int AW = MR_AW_DEF,
    parameter int DW = MR_DW_DEF
) (
    input  logic          clk,
    input  logic          rstbar,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
`ifdef MEM_READER_CHECKSUM_EN
    output logic [DW-1:0] sum,
`endif
    output mr_state_t     dbg_state_o,
    mem_reader_if.master  bus
);

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   REM_ONE  = (AW + 1)'(1);

    mr_state_t     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic          pending_q, pending_d;   // a read was issued last cycle

    logic          ram_re;
    logic          credit;
    logic          hs;
    logic          buf_q_valid;
    logic [DW-1:0] buf_q_data;
    logic [1:0]    buf_count;
    logic [1:0]    occ_after;

    mem_reader_buf #(.DW(DW)) u_buf (
        .clk       (clk),
        .rstbar    (rstbar),
        .push      (pending_q),
        .push_data (bus.ram_rdata),
        .pop       (hs),
        .q_valid   (buf_q_valid),
        .q_data    (buf_q_data),
        .count     (buf_count)
    );

    always_comb begin
        hs     = buf_q_valid && bus.q_ready;
        credit = credit_ok(buf_count, pending_q);
        // Words still owed to the consumer after this edge. In DRAIN no new
        // read is issued, so this is the complete outstanding count.
        occ_after = buf_count + {1'b0, pending_q} - {1'b0, hs};
    end

    // Next-state and outputs
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        ram_re  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d  = base;
                        rem_d   = len;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (credit) begin
                    ram_re = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (occ_after == 2'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pending_d = ram_re;
    end

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            pending_q <= pending_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign dbg_state_o  = state_q;
    assign bus.ram_re   = ram_re;
    assign bus.ram_addr = addr_q;
    assign bus.q_valid  = buf_q_valid;
    assign bus.q_data   = buf_q_data;

`ifdef MEM_READER_CHECKSUM_EN
    logic [DW-1:0] sum_q;

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            sum_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            sum_q <= '0;
        end else if (hs) begin
            sum_q <= sum_q ^ buf_q_data;
        end
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_mem_reader.sv
// -----------------------------------------------------------------------------
// tb_mem_reader
// Self-checking bench for mem_reader with a synchronous RAM model, a word
// scoreboard (exp_q) filled when a transfer is started and drained by the
// output monitor, and one task per scenario.
// Honours MEM_READER_CHECKSUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_mem_reader;
    import mem_reader_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rstbar = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    mr_state_t     dbg_state;
`ifdef MEM_READER_CHECKSUM_EN
    logic [DW-1:0] sum;
`endif

    mem_reader_if #(.AW(AW), .DW(DW)) bus ();

    mem_reader #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rstbar      (rstbar),
        .start       (start),
        .base        (base),
        .len         (len),
        .busy        (busy),
        .done        (done),
`ifdef MEM_READER_CHECKSUM_EN
        .sum         (sum),
`endif
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model, one cycle read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    end

    // ---------------- scoreboard state ----------------
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_sum = '0;
    logic [AW-1:0] mon_exp_addr = '0;
    int            rd_cnt = 0;
    int            hs_cnt = 0;
    int            outstanding = 0;
    int            xfer_len = 0;
    int            start_cyc = 0;
    int            first_re_cyc = -1;
    int            first_valid_cyc = -1;
    int            last_hs_cyc = -1;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            ready_mode = 0;
    int            phase = 0;

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [DW-1:0] exp_w;
        int            exp_done_cyc;
        if (!rstbar) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            if (bus.ram_re) begin
                total++;
                if (bus.ram_addr !== mon_exp_addr) begin
                    bad++;
                    $display("FAIL ram_addr: got %0d expected %0d at cycle %0d", bus.ram_addr, mon_exp_addr, cyc);
                end
                total++;
                if (outstanding >= 2) begin
                    bad++;
                    $display("FAIL credit: ram_re with %0d words outstanding (allowed <2)", outstanding);
                end
                if (first_re_cyc < 0) first_re_cyc = cyc;
                mon_exp_addr = mon_exp_addr + 1'b1;
                rd_cnt++;
            end
            if (stall_prev) begin
                total++;
                if (bus.q_valid !== 1'b1 || bus.q_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", bus.q_valid, bus.q_data, prev_data);
                end
            end
            if (bus.q_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.q_valid && bus.q_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got %h expected none", bus.q_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.q_data !== exp_w) begin
                        bad++;
                        $display("FAIL q_data: got %h expected %h", bus.q_data, exp_w);
                    end
                end
                last_hs_cyc = cyc;
                hs_cnt++;
            end
            outstanding = outstanding + int'(bus.ram_re) - int'(bus.q_valid && bus.q_ready);
            if (done) begin
                total++;
                if (exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL done_early: %0d words left, expected 0", exp_q.size());
                end
                exp_done_cyc = (xfer_len == 0) ? start_cyc + 1 : last_hs_cyc + 1;
                total++;
                if (cyc != exp_done_cyc) begin
                    bad++;
                    $display("FAIL done_timing: got cycle %0d expected %0d", cyc, exp_done_cyc);
                end
                total++;
                if (rd_cnt != xfer_len) begin
                    bad++;
                    $display("FAIL read_count: got %0d expected %0d", rd_cnt, xfer_len);
                end
`ifdef MEM_READER_CHECKSUM_EN
                total++;
                if (sum !== exp_sum) begin
                    bad++;
                    $display("FAIL checksum: got %h expected %h", sum, exp_sum);
                end
`endif
            end
            stall_prev = bus.q_valid && !bus.q_ready;
            prev_data  = bus.q_data;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic ready_for(input int p);
        case (ready_mode)
            0:       return 1'b1;
            1:       return (p % 3) == 0;   // 1,0,0,1,0,0,...
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        exp_q.delete();
        exp_sum = '0;
        a = b;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(mem[a]);
            exp_sum = exp_sum ^ mem[a];
            a = a + 1'b1;
        end
        mon_exp_addr    = b;
        rd_cnt          = 0;
        hs_cnt          = 0;
        xfer_len        = int'(l);
        start_cyc       = cyc;
        first_re_cyc    = -1;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        phase           = 0;
        start           = 1'b1;
        base            = b;
        len             = l;
        bus.q_ready     = ready_for(phase);
        @(posedge clk); #1;
        start       = 1'b0;
        phase       = 1;
        bus.q_ready = ready_for(phase);
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk); #1;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                phase++;
                bus.q_ready = ready_for(phase);
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end else begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.ram_re !== 1'b0 || bus.ram_addr !== '0 ||
            bus.q_valid !== 1'b0 || bus.q_data !== '0) begin
            bad++;
            $display("FAIL %s: got busy=%b done=%b re=%b addr=%h valid=%b data=%h expected all 0",
                     tag, busy, done, bus.ram_re, bus.ram_addr, bus.q_valid, bus.q_data);
        end
`ifdef MEM_READER_CHECKSUM_EN
        total++;
        if (sum !== '0) begin
            bad++;
            $display("FAIL %s_sum: got %h expected 0", tag, sum);
        end
`endif
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.q_ready = 1'b1;
        #2 rstbar = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        @(posedge clk); #1;
        rstbar = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        ready_mode = 0;
        start_xfer(4'd3, 5'd4);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        wait_done(100);
        total++;
        if (first_re_cyc != start_cyc + 1 || first_valid_cyc != start_cyc + 2) begin
            bad++;
            $display("FAIL latency: got re=%0d valid=%0d expected re=%0d valid=%0d",
                     first_re_cyc, first_valid_cyc, start_cyc + 1, start_cyc + 2);
        end
        total++;
        if (hs_cnt != 4 || last_hs_cyc != start_cyc + 5) begin
            bad++;
            $display("FAIL throughput: got %0d words last at %0d expected 4 last at %0d",
                     hs_cnt, last_hs_cyc, start_cyc + 5);
        end
    endtask

    task automatic test_wrap();
        ready_mode = 0;
        start_xfer(4'd14, 5'd4);
        wait_done(100);
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        start_xfer(4'd1, 5'd6);
        wait_done(200);
        total++;
        if (hs_cnt != 6) begin
            bad++;
            $display("FAIL bp_words: got %0d expected 6", hs_cnt);
        end
        ready_mode = 0;
    endtask

    task automatic test_zero_len();
        ready_mode = 0;
        start_xfer(4'd5, 5'd0);
        wait_done(10);
        total++;
        if (rd_cnt != 0) begin
            bad++;
            $display("FAIL zero_len_reads: got %0d expected 0", rd_cnt);
        end
    endtask

    task automatic test_full_len();
        ready_mode = 2;
        start_xfer(4'd7, 5'd16);
        wait_done(400);
        total++;
        if (bus.ram_addr !== 4'd7) begin
            bad++;
            $display("FAIL full_wrap_addr: got %0d expected 7", bus.ram_addr);
        end
        ready_mode = 0;
    endtask

    task automatic test_random();
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
            start_xfer(4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)));
            wait_done(400);
        end
        ready_mode = 0;
    endtask

    task automatic test_start_busy();
        ready_mode = 0;
        start_xfer(4'd2, 5'd5);
        @(posedge clk); #1;
        start = 1'b1;
        base  = 4'd9;
        len   = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
    endtask

    task automatic test_reset_mid();
        bit reached;
        ready_mode = 0;
        reached = 1'b0;
        start_xfer(4'd0, 5'd8);
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk); #1;
            if (hs_cnt >= 2) reached = 1'b1;
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL mid_progress: got %0d words expected 2", hs_cnt);
        end
        @(posedge clk); #1;
        rstbar = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_done: got %b expected 0", done);
        end
        rstbar = 1'b1;
        start_xfer(4'd5, 5'd3);
        wait_done(100);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.q_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 8'h10);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full_len();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
